// File: rtl/idex_operand_stage.sv
// ID/EX operand stage: one-entry buffer between decode and the ALU, with RAW forwarding and load-use stall.
// Optional macro IDEX_FORWARD_EN enables the MEM/WB forwarding muxes; when it is undefined the stage stalls until hazards retire.
module idex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RW-1:0]   id_rs1,
    input  logic [RW-1:0]   id_rs2,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_alusrc,
    input  logic [2:0]      id_alucontrol,
    input  logic            id_regwrite,
    input  logic            id_memtoreg,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] srca,
    output logic [XLEN-1:0] srcb,
    output logic [2:0]      alucontrol,
    output logic [XLEN-1:0] ex_writedata,
    output logic [RW-1:0]   ex_rd,
    output logic            ex_regwrite,
    output logic            ex_memtoreg,
    input  logic [RW-1:0]   mem_rd,
    input  logic            mem_regwrite,
    input  logic            mem_memtoreg,
    input  logic [XLEN-1:0] mem_aluresult,
    input  logic [RW-1:0]   wb_rd,
    input  logic            wb_regwrite,
    input  logic [XLEN-1:0] wb_result
);

    logic            v;
    logic [XLEN-1:0] rd1_q, rd2_q, imm_q;
    logic [RW-1:0]   rs1_q, rs2_q, rd_q;
    logic            alusrc_q;
    logic [2:0]      alucontrol_q;
    logic            regwrite_q, memtoreg_q;

    logic            stall;
    logic            ex_fire, id_fire;
    logic [XLEN-1:0] fwd1, fwd2;

`ifdef IDEX_FORWARD_EN
    // ALU results in MEM win over WB; a load in MEM has no value yet and is covered by the stall.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RW-1:0]   idx,
        input logic [XLEN-1:0] held,
        input logic [RW-1:0]   m_rd,
        input logic            m_rw,
        input logic            m_mtr,
        input logic [XLEN-1:0] m_res,
        input logic [RW-1:0]   w_rd,
        input logic            w_rw,
        input logic [XLEN-1:0] w_res
    );
        logic [XLEN-1:0] r;
        r = held;
        if (idx != '0) begin
            if (m_rw && !m_mtr && (m_rd == idx))
                r = m_res;
            else if (w_rw && (w_rd == idx))
                r = w_res;
        end
        return r;
    endfunction

    always_comb begin
        fwd1  = fwd_sel(rs1_q, rd1_q, mem_rd, mem_regwrite, mem_memtoreg, mem_aluresult,
                        wb_rd, wb_regwrite, wb_result);
        fwd2  = fwd_sel(rs2_q, rd2_q, mem_rd, mem_regwrite, mem_memtoreg, mem_aluresult,
                        wb_rd, wb_regwrite, wb_result);
        stall = v && mem_regwrite && mem_memtoreg && (mem_rd != '0)
                && ((mem_rd == rs1_q) || (mem_rd == rs2_q));
    end
`else
    function automatic logic pending(
        input logic [RW-1:0] idx,
        input logic [RW-1:0] m_rd,
        input logic          m_rw,
        input logic [RW-1:0] w_rd,
        input logic          w_rw
    );
        return (idx != '0) && ((m_rw && (m_rd == idx)) || (w_rw && (w_rd == idx)));
    endfunction

    // Without forwarding the value paths below are not needed; fold them into a sink.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{mem_memtoreg, mem_aluresult, wb_result};

    always_comb begin
        fwd1  = rd1_q;
        fwd2  = rd2_q;
        stall = v && (pending(rs1_q, mem_rd, mem_regwrite, wb_rd, wb_regwrite)
                   || pending(rs2_q, mem_rd, mem_regwrite, wb_rd, wb_regwrite));
    end
`endif

    assign ex_valid = v & ~stall;
    assign ex_fire  = ex_valid & ex_ready;
    assign id_ready = (~v | ex_fire) & ~flush;
    assign id_fire  = id_valid & id_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v            <= 1'b0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            alusrc_q     <= 1'b0;
            alucontrol_q <= 3'b000;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (id_fire) begin
            v            <= 1'b1;
            rd1_q        <= id_rd1;
            rd2_q        <= id_rd2;
            imm_q        <= id_imm;
            rs1_q        <= id_rs1;
            rs2_q        <= id_rs2;
            rd_q         <= id_rd;
            alusrc_q     <= id_alusrc;
            alucontrol_q <= id_alucontrol;
            regwrite_q   <= id_regwrite;
            memtoreg_q   <= id_memtoreg;
        end else if (ex_fire) begin
            v <= 1'b0;
        end
    end

    assign srca         = fwd1;
    assign srcb         = alusrc_q ? imm_q : fwd2;
    assign ex_writedata = fwd2;
    assign alucontrol   = alucontrol_q;
    assign ex_rd        = rd_q;
    assign ex_regwrite  = regwrite_q;
    assign ex_memtoreg  = memtoreg_q;

endmodule

// File: tb/tb_idex_operand_stage.sv
// Bench for idex_operand_stage: table vectors, directed multi-cycle sequences and random traffic against a reference model.
// Expected values follow IDEX_FORWARD_EN in the same way as the design build.
module tb_idex_operand_stage;

`ifdef IDEX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_ready;
    logic [31:0] id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_alusrc;
    logic [2:0]  id_alucontrol;
    logic        id_regwrite, id_memtoreg;
    logic        flush, ex_ready, ex_valid;
    logic [31:0] srca, srcb, ex_writedata;
    logic [2:0]  alucontrol;
    logic [4:0]  ex_rd;
    logic        ex_regwrite, ex_memtoreg;
    logic [4:0]  mem_rd;
    logic        mem_regwrite, mem_memtoreg;
    logic [31:0] mem_aluresult;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [31:0] wb_result;

    always #5 clk = ~clk;

    idex_operand_stage #(.XLEN(32), .RW(5)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alusrc(id_alusrc), .id_alucontrol(id_alucontrol),
        .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .srca(srca), .srcb(srcb), .alucontrol(alucontrol),
        .ex_writedata(ex_writedata), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
        .mem_aluresult(mem_aluresult),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        alusrc;
        logic [2:0]  aluc;
        logic        rw, mtr;
    } entry_t;

    entry_t m;
    bit     m_v;

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic [31:0] rd1, rd2, imm;
        logic        alusrc;
        logic [4:0]  mem_rd;
        logic        mem_rw, mem_mtr;
        logic [31:0] mem_res;
        logic [4:0]  wb_rd;
        logic        wb_rw;
        logic [31:0] wb_res;
        logic [31:0] e_a, e_b, e_wd;
        logic        e_v;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: value a source register should read given what is in flight downstream.
    function automatic logic [31:0] m_operand(input logic [4:0] idx, input logic [31:0] held);
        if (!FWD || idx == 0) return held;
        if (mem_regwrite && !mem_memtoreg && mem_rd == idx) return mem_aluresult;
        if (wb_regwrite && wb_rd == idx) return wb_result;
        return held;
    endfunction

    function automatic bit m_stall();
        logic [4:0] srcs[2];
        bit s;
        if (!m_v) return 1'b0;
        srcs[0] = m.rs1;
        srcs[1] = m.rs2;
        s = 1'b0;
        foreach (srcs[k]) begin
            if (srcs[k] != 0) begin
                if (FWD)
                    s |= mem_regwrite && mem_memtoreg && mem_rd == srcs[k];
                else
                    s |= (mem_regwrite && mem_rd == srcs[k]) || (wb_regwrite && wb_rd == srcs[k]);
            end
        end
        return s;
    endfunction

    function automatic bit m_ex_valid();
        return m_v && !m_stall();
    endfunction

    function automatic bit m_id_ready();
        return (!m_v || (m_ex_valid() && ex_ready)) && !flush;
    endfunction

    task automatic check_model();
        logic [31:0] b2;
        b2 = m_operand(m.rs2, m.rd2);
        chk("id_ready", {31'b0, id_ready}, {31'b0, m_id_ready()});
        chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_ex_valid()});
        chk("srca", srca, m_operand(m.rs1, m.rd1));
        chk("srcb", srcb, m.alusrc ? m.imm : b2);
        chk("ex_writedata", ex_writedata, b2);
        chk("alucontrol", {29'b0, alucontrol}, {29'b0, m.aluc});
        chk("ex_rd", {27'b0, ex_rd}, {27'b0, m.rd});
        chk("ex_ctrl", {30'b0, ex_regwrite, ex_memtoreg}, {30'b0, m.rw, m.mtr});
    endtask

    task automatic sample();
        #2;
        check_model();
    endtask

    task automatic advance();
        entry_t nm;
        bit     nv;
        nm = m;
        nv = m_v;
        if (!reset) begin
            nv = 1'b0;
            nm = '{default: '0};
        end else if (flush) begin
            nv = 1'b0;
        end else if (id_valid && m_id_ready()) begin
            nv = 1'b1;
            nm = '{rd1: id_rd1, rd2: id_rd2, imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                   alusrc: id_alusrc, aluc: id_alucontrol, rw: id_regwrite, mtr: id_memtoreg};
        end else if (m_ex_valid() && ex_ready) begin
            nv = 1'b0;
        end
        @(posedge clk);
        #1;
        m   = nm;
        m_v = nv;
    endtask

    task automatic env_idle();
        mem_rd = 0; mem_regwrite = 0; mem_memtoreg = 0; mem_aluresult = 0;
        wb_rd = 0; wb_regwrite = 0; wb_result = 0;
    endtask

    task automatic set_id(input logic vld, input logic [4:0] rs1, input logic [31:0] rd1,
                          input logic [4:0] rs2, input logic [31:0] rd2, input logic [31:0] imm,
                          input logic alusrc, input logic [2:0] aluc);
        id_valid = vld; id_rs1 = rs1; id_rd1 = rd1; id_rs2 = rs2; id_rd2 = rd2;
        id_imm = imm; id_alusrc = alusrc; id_alucontrol = aluc;
        id_rd = 5'd9; id_regwrite = 1'b1; id_memtoreg = 1'b0;
    endtask

    task automatic drain();
        flush = 1; id_valid = 0; env_idle();
        sample(); advance();
        flush = 0;
    endtask

    function automatic vec_t mkv(input logic [4:0] rs1, input logic [31:0] rd1,
                                 input logic [4:0] rs2, input logic [31:0] rd2,
                                 input logic [31:0] imm, input logic alusrc,
                                 input logic [4:0] mrd, input logic mrw, input logic mmtr,
                                 input logic [31:0] mres, input logic [4:0] wrd,
                                 input logic wrw, input logic [31:0] wres,
                                 input logic [31:0] ea, input logic [31:0] eb,
                                 input logic [31:0] ewd, input logic ev);
        vec_t t;
        t = '{rs1: rs1, rs2: rs2, rd1: rd1, rd2: rd2, imm: imm, alusrc: alusrc,
              mem_rd: mrd, mem_rw: mrw, mem_mtr: mmtr, mem_res: mres,
              wb_rd: wrd, wb_rw: wrw, wb_res: wres, e_a: ea, e_b: eb, e_wd: ewd, e_v: ev};
        return t;
    endfunction

    initial begin
        m   = '{default: '0};
        m_v = 1'b0;
        reset = 0; flush = 0; ex_ready = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        env_idle();

        //           rs1 rd1     rs2 rd2   imm    as mrd mrw mtr mres   wrd wrw wres   srca / srcb / wd / valid
        vecs[0] = mkv(1, 32'h5,   2, 32'h7, 32'h0, 0, 0, 0, 0, 32'h0,  0, 0, 32'h0,
                      32'h5, 32'h7, 32'h7, 1);
        vecs[1] = mkv(3, 32'h0,   6, 32'h9, 32'h0, 0, 3, 1, 0, 32'h64, 0, 0, 32'h0,
                      FWD ? 32'h64 : 32'h0, 32'h9, 32'h9, FWD);
        vecs[2] = mkv(0, 32'h0,   6, 32'h9, 32'h0, 0, 0, 1, 0, 32'h64, 0, 0, 32'h0,
                      32'h0, 32'h9, 32'h9, 1);
        vecs[3] = mkv(1, 32'h11,  4, 32'h2, 32'h0, 0, 4, 1, 0, 32'hA,  4, 1, 32'hB,
                      32'h11, FWD ? 32'hA : 32'h2, FWD ? 32'hA : 32'h2, FWD);
        vecs[4] = mkv(1, 32'h11,  4, 32'h2, 32'h10, 1, 4, 1, 0, 32'hA, 4, 1, 32'hB,
                      32'h11, 32'h10, FWD ? 32'hA : 32'h2, FWD);
        vecs[5] = mkv(7, 32'h1,   0, 32'h3, 32'h0, 0, 0, 0, 0, 32'h0,  7, 1, 32'h77,
                      FWD ? 32'h77 : 32'h1, 32'h3, 32'h3, FWD);
        vecs[6] = mkv(0, 32'h4,   8, 32'h6, 32'h20, 1, 8, 1, 1, 32'h55, 0, 0, 32'h0,
                      32'h4, 32'h20, 32'h6, 0);

        repeat (2) @(posedge clk);
        #1;
        sample();
        chk("reset ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("reset srca", srca, 32'h0);
        chk("reset alucontrol", {29'b0, alucontrol}, 32'h0);
        advance();
        reset = 1;

        // Table vectors: load the entry with EX stalled, then present the downstream state.
        foreach (vecs[i]) begin
            drain();
            ex_ready = 0;
            set_id(1, vecs[i].rs1, vecs[i].rd1, vecs[i].rs2, vecs[i].rd2, vecs[i].imm,
                   vecs[i].alusrc, 3'b010);
            sample(); advance();
            id_valid = 0;
            mem_rd = vecs[i].mem_rd; mem_regwrite = vecs[i].mem_rw;
            mem_memtoreg = vecs[i].mem_mtr; mem_aluresult = vecs[i].mem_res;
            wb_rd = vecs[i].wb_rd; wb_regwrite = vecs[i].wb_rw; wb_result = vecs[i].wb_res;
            sample();
            chk($sformatf("vec%0d srca", i), srca, vecs[i].e_a);
            chk($sformatf("vec%0d srcb", i), srcb, vecs[i].e_b);
            chk($sformatf("vec%0d wdata", i), ex_writedata, vecs[i].e_wd);
            chk($sformatf("vec%0d ex_valid", i), {31'b0, ex_valid}, {31'b0, vecs[i].e_v});
            advance();
        end

        // Asynchronous reset in the middle of a held transfer.
        drain();
        ex_ready = 0;
        set_id(1, 5'd3, 32'h99, 5'd0, 32'h0, 32'h0, 0, 3'b101);
        sample(); advance();
        set_id(1, 5'd6, 32'h42, 5'd0, 32'h0, 32'h0, 0, 3'b110);
        mem_rd = 3; mem_regwrite = 1; mem_aluresult = 32'hDEAD;
        #2;
        reset = 0;
        #1;
        m = '{default: '0};
        m_v = 1'b0;
        chk("midreset ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("midreset srca", srca, 32'h0);
        chk("midreset alucontrol", {29'b0, alucontrol}, 32'h0);
        check_model();
        advance();
        reset = 1;
        env_idle();
        ex_ready = 1;
        set_id(1, 5'd1, 32'h5, 5'd2, 32'h7, 32'h0, 0, 3'b000);
        sample(); advance();
        id_valid = 0;
        sample();
        chk("add ex_valid", {31'b0, ex_valid}, 32'h1);
        chk("add srca", srca, 32'h5);
        chk("add srcb", srcb, 32'h7);
        chk("add alucontrol", {29'b0, alucontrol}, 32'h0);
        advance();

        // Load-use: load to x5 in MEM, then it reaches WB.
        drain();
        ex_ready = 1;
        set_id(1, 5'd5, 32'h0, 5'd0, 32'h0, 32'h0, 0, 3'b010);
        sample(); advance();
        set_id(1, 5'd0, 32'h21, 5'd0, 32'h0, 32'h0, 0, 3'b011);
        mem_rd = 5; mem_regwrite = 1; mem_memtoreg = 1;
        sample();
        chk("loaduse ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("loaduse id_ready", {31'b0, id_ready}, 32'h0);
        advance();
        env_idle();
        wb_rd = 5; wb_regwrite = 1; wb_result = 32'h33;
        sample();
        chk("loaduse release", {31'b0, ex_valid}, {31'b0, FWD});
        if (FWD) chk("loaduse srca", srca, 32'h33);
        advance();
        id_valid = 0;
        env_idle();
        sample();
        chk("loaduse after", {31'b0, ex_valid}, 32'h1);
        advance();

        // Backpressure for three cycles, then flush with a competing request.
        drain();
        ex_ready = 0;
        set_id(1, 5'd1, 32'h55, 5'd0, 32'h0, 32'h0, 0, 3'b100);
        sample(); advance();
        for (int c = 0; c < 3; c++) begin
            set_id(1, 5'($urandom_range(0, 7)), $urandom, 5'd0, $urandom, $urandom, 0, 3'b001);
            sample();
            chk("bp id_ready", {31'b0, id_ready}, 32'h0);
            chk("bp srca", srca, 32'h55);
            chk("bp alucontrol", {29'b0, alucontrol}, 32'h4);
            advance();
        end
        flush = 1;
        set_id(1, 5'd2, 32'h66, 5'd0, 32'h0, 32'h0, 0, 3'b111);
        sample();
        chk("flush id_ready", {31'b0, id_ready}, 32'h0);
        advance();
        flush = 0; id_valid = 0;
        sample();
        chk("flush ex_valid", {31'b0, ex_valid}, 32'h0);
        chk("flush not loaded", {29'b0, alucontrol}, 32'h4);
        advance();

        // Back-to-back issue, one instruction per cycle.
        ex_ready = 1;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) set_id(1, 5'd0, 32'(i + 1), 5'd0, 32'h0, 32'h0, 0, 3'b010);
            else id_valid = 0;
            set_id(id_valid, 5'd0, 32'(i + 1), 5'd0, 32'h0, 32'h0, 0, 3'b010);
            id_rs1 = 5'd0;
            sample();
            if (i > 0) begin
                chk("b2b ex_valid", {31'b0, ex_valid}, 32'h1);
                chk("b2b srca", srca, 32'(i));
            end
            if (i < 4) chk("b2b id_ready", {31'b0, id_ready}, 32'h1);
            advance();
        end

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom), 3'($urandom));
            id_rd = 5'($urandom_range(0, 7));
            id_memtoreg = 1'($urandom);
            flush = ($urandom_range(0, 9) == 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            mem_rd = 5'($urandom_range(0, 7)); mem_regwrite = 1'($urandom);
            mem_memtoreg = 1'($urandom); mem_aluresult = $urandom;
            wb_rd = 5'($urandom_range(0, 7)); wb_regwrite = 1'($urandom); wb_result = $urandom;
            sample(); advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
